// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: shares one core-side CLIC interrupt handshake among N_TARGETS target channels,
// ranked by {effective mode, level}, with kill on withdrawal request or strict-rank preemption.
module clic_irq_arbiter #(
    parameter int N_TARGETS = 2,
    parameter int SrcWidth  = 8,
    parameter int PrioWidth = 8,
    parameter int ModeWidth = 2,
    parameter int VsidWidth = 6,
    localparam int TgtWidth = $clog2(N_TARGETS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_TARGETS-1:0]                 tgt_valid_i,
    output logic [N_TARGETS-1:0]                 tgt_ready_o,
    input  logic [N_TARGETS-1:0][SrcWidth-1:0]   tgt_id_i,
    input  logic [N_TARGETS-1:0][PrioWidth-1:0]  tgt_max_i,
    input  logic [N_TARGETS-1:0][ModeWidth-1:0]  tgt_mode_i,
    input  logic [N_TARGETS-1:0][VsidWidth-1:0]  tgt_vsid_i,
    input  logic [N_TARGETS-1:0]                 tgt_v_i,
    input  logic [N_TARGETS-1:0]                 tgt_shv_i,
    input  logic [N_TARGETS-1:0]                 tgt_kill_req_i,
    output logic [N_TARGETS-1:0]                 tgt_kill_ack_o,
    output logic                                 irq_valid_o,
    input  logic                                 irq_ready_i,
    output logic [SrcWidth-1:0]                  irq_id_o,
    output logic [PrioWidth-1:0]                 irq_max_o,
    output logic [ModeWidth-1:0]                 irq_mode_o,
    output logic [VsidWidth-1:0]                 irq_vsid_o,
    output logic                                 irq_v_o,
    output logic                                 irq_shv_o,
    output logic [TgtWidth-1:0]                  irq_tgt_o,
    output logic                                 irq_kill_req_o,
    input  logic                                 irq_kill_ack_i
);
    localparam int RankWidth = ModeWidth + PrioWidth;

    typedef enum logic [1:0] {IDLE, OFFER, KILL} state_e;

    state_e                             state_q, state_d;
    logic [TgtWidth-1:0]                sel_q, win;
    logic                               kill_src_q, kill_src_d;
    logic                               latch, preempt;
    logic [N_TARGETS-1:0][RankWidth-1:0] rank;
    logic [RankWidth-1:0]               win_rank, cur_rank;

    if (N_TARGETS < 2) begin : g_check
        $error("clic_irq_arbiter: N_TARGETS must be at least 2");
    end

    // Non-virtualized S is promoted above virtualized S so hypervisor-level requests win.
    function automatic logic [RankWidth-1:0] rank_of(input logic [ModeWidth-1:0] mode,
                                                     input logic v,
                                                     input logic [PrioWidth-1:0] prio);
        return {(mode == ModeWidth'(1) && !v) ? ModeWidth'(2) : mode, prio};
    endfunction

    always_comb begin
        for (int i = 0; i < N_TARGETS; i++) rank[i] = rank_of(tgt_mode_i[i], tgt_v_i[i], tgt_max_i[i]);
    end

    always_comb begin
        win      = '0;
        win_rank = rank[0];
        for (int i = 1; i < N_TARGETS; i++)
            if (tgt_valid_i[i] && (!tgt_valid_i[win] || rank[i] > win_rank)) begin
                win      = TgtWidth'(i);
                win_rank = rank[i];
            end
    end

    assign cur_rank = rank_of(irq_mode_o, irq_v_o, irq_max_o);

    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < N_TARGETS; i++)
            if (TgtWidth'(i) != sel_q && tgt_valid_i[i] && rank[i] > cur_rank) preempt = 1'b1;
    end

    // Valid follows the live request so a withdrawn level-sensitive interrupt is never accepted.
    assign irq_valid_o    = (state_q != IDLE) && tgt_valid_i[sel_q];
    assign irq_kill_req_o = (state_q == KILL);
    assign irq_tgt_o      = sel_q;

    always_comb begin
        state_d        = state_q;
        kill_src_d     = kill_src_q;
        latch          = 1'b0;
        tgt_ready_o    = '0;
        tgt_kill_ack_o = '0;
        case (state_q)
            IDLE: if (|tgt_valid_i) begin
                latch   = 1'b1;
                state_d = OFFER;
            end
            OFFER: if (irq_valid_o && irq_ready_i) begin
                tgt_ready_o[sel_q] = 1'b1;
                state_d            = IDLE;
            end else if (!tgt_valid_i[sel_q]) begin
                state_d = IDLE;
            end else if (tgt_kill_req_i[sel_q]) begin
                kill_src_d = 1'b1;
                state_d    = KILL;
            end else if (preempt) begin
                kill_src_d = 1'b0;
                state_d    = KILL;
            end
            KILL: if (irq_valid_o && irq_ready_i) begin
                tgt_ready_o[sel_q] = 1'b1;
                state_d            = IDLE;
            end else if (!tgt_valid_i[sel_q]) begin
                state_d = IDLE;
            end else if (irq_kill_ack_i) begin
                tgt_kill_ack_o[sel_q] = kill_src_q;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            kill_src_q <= 1'b0;
            sel_q      <= '0;
            irq_id_o   <= '0;
            irq_max_o  <= '0;
            irq_mode_o <= '0;
            irq_vsid_o <= '0;
            irq_v_o    <= 1'b0;
            irq_shv_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_src_q <= kill_src_d;
            if (latch) begin
                sel_q      <= win;
                irq_id_o   <= tgt_id_i[win];
                irq_max_o  <= tgt_max_i[win];
                irq_mode_o <= tgt_mode_i[win];
                irq_vsid_o <= tgt_vsid_i[win];
                irq_v_o    <= tgt_v_i[win];
                irq_shv_o  <= tgt_shv_i[win];
            end
        end
    end
endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb_clic_irq_arbiter: directed scenarios for the two-channel CLIC arbiter with hand-computed expectations.
module tb_clic_irq_arbiter;
    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [1:0]      tgt_valid, tgt_ready, tgt_v, tgt_shv, tgt_kill_req, tgt_kill_ack;
    logic [1:0][7:0] tgt_id, tgt_max;
    logic [1:0][1:0] tgt_mode;
    logic [1:0][5:0] tgt_vsid;
    logic            irq_valid, irq_ready, irq_v, irq_shv, irq_tgt, irq_kill_req, irq_kill_ack;
    logic [7:0]      irq_id, irq_max;
    logic [1:0]      irq_mode;
    logic [5:0]      irq_vsid;
    int              vectors = 0;
    int              miscompares = 0;

    clic_irq_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .tgt_valid_i(tgt_valid), .tgt_ready_o(tgt_ready),
        .tgt_id_i(tgt_id), .tgt_max_i(tgt_max), .tgt_mode_i(tgt_mode), .tgt_vsid_i(tgt_vsid),
        .tgt_v_i(tgt_v), .tgt_shv_i(tgt_shv),
        .tgt_kill_req_i(tgt_kill_req), .tgt_kill_ack_o(tgt_kill_ack),
        .irq_valid_o(irq_valid), .irq_ready_i(irq_ready),
        .irq_id_o(irq_id), .irq_max_o(irq_max), .irq_mode_o(irq_mode), .irq_vsid_o(irq_vsid),
        .irq_v_o(irq_v), .irq_shv_o(irq_shv), .irq_tgt_o(irq_tgt),
        .irq_kill_req_o(irq_kill_req), .irq_kill_ack_i(irq_kill_ack)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // vsid and shv are derived from the id so payload checks cover every field.
    task automatic set_ch(input int c, input logic vld, input logic [7:0] id, input logic [7:0] pr,
                          input logic [1:0] md, input logic v);
        tgt_valid[c] = vld;
        tgt_id[c]    = id;
        tgt_max[c]   = pr;
        tgt_mode[c]  = md;
        tgt_vsid[c]  = id[5:0];
        tgt_v[c]     = v;
        tgt_shv[c]   = id[0];
    endtask

    task automatic test_reset();
        @(negedge clk_i); #1;
        vectors++; if (irq_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", irq_valid); end
        vectors++; if (irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL rst_kill got %b want 0", irq_kill_req); end
        vectors++; if (tgt_ready !== 2'b00) begin miscompares++; $display("FAIL rst_ready got %b want 00", tgt_ready); end
        vectors++; if (tgt_kill_ack !== 2'b00) begin miscompares++; $display("FAIL rst_kill_ack got %b want 00", tgt_kill_ack); end
        vectors++; if (irq_id !== 8'd0 || irq_tgt !== 1'b0) begin miscompares++; $display("FAIL rst_payload got id=%h tgt=%b want 00/0", irq_id, irq_tgt); end
        rst_ni = 1'b1;
        step();
        vectors++; if (irq_valid !== 1'b0 || irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL rst_idle got v=%b k=%b want 0/0", irq_valid, irq_kill_req); end
    endtask

    task automatic test_basic();
        set_ch(0, 1'b1, 8'd3, 8'd5, 2'b11, 1'b0); #1;
        vectors++; if (irq_valid !== 1'b0) begin miscompares++; $display("FAIL basic_delay got %b want 0", irq_valid); end
        step();
        vectors++; if (irq_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", irq_valid); end
        vectors++; if (irq_id !== 8'd3) begin miscompares++; $display("FAIL basic_id got %h want 03", irq_id); end
        vectors++; if (irq_mode !== 2'b11) begin miscompares++; $display("FAIL basic_mode got %b want 11", irq_mode); end
        vectors++; if (irq_tgt !== 1'b0) begin miscompares++; $display("FAIL basic_tgt got %b want 0", irq_tgt); end
        vectors++; if (irq_max !== 8'd5) begin miscompares++; $display("FAIL basic_max got %0d want 5", irq_max); end
        vectors++; if (irq_vsid !== 6'd3 || irq_shv !== 1'b1) begin miscompares++; $display("FAIL basic_vsid_shv got %0d/%b want 3/1", irq_vsid, irq_shv); end
        vectors++; if (tgt_ready !== 2'b00) begin miscompares++; $display("FAIL basic_no_ready got %b want 00", tgt_ready); end
        tgt_id[0] = 8'd9;
        step();
        vectors++; if (irq_id !== 8'd3) begin miscompares++; $display("FAIL basic_stable got %h want 03", irq_id); end
        step();
        irq_ready = 1'b1; #1;
        vectors++; if (tgt_ready !== 2'b01) begin miscompares++; $display("FAIL basic_ready got %b want 01", tgt_ready); end
        step();
        irq_ready = 1'b0; #1;
        vectors++; if (tgt_ready !== 2'b00) begin miscompares++; $display("FAIL basic_ready_pulse got %b want 00", tgt_ready); end
        vectors++; if (irq_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle got %b want 0", irq_valid); end
        tgt_valid = 2'b00;
        step();
    endtask

    task automatic test_rank();
        set_ch(0, 1'b1, 8'h10, 8'd200, 2'b01, 1'b1);
        set_ch(1, 1'b1, 8'h21, 8'd10, 2'b01, 1'b0);
        step();
        vectors++; if (irq_tgt !== 1'b1 || irq_v !== 1'b0) begin miscompares++; $display("FAIL rank_hs_tgt got %b/v=%b want 1/0", irq_tgt, irq_v); end
        vectors++; if (irq_id !== 8'h21 || irq_max !== 8'd10) begin miscompares++; $display("FAIL rank_hs_payload got %h/%0d want 21/10", irq_id, irq_max); end
        vectors++; if (irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL rank_hs_no_kill got %b want 0", irq_kill_req); end
        irq_ready = 1'b1; #1;
        vectors++; if (tgt_ready !== 2'b10) begin miscompares++; $display("FAIL rank_hs_ready got %b want 10", tgt_ready); end
        step();
        irq_ready = 1'b0;
        set_ch(0, 1'b1, 8'h01, 8'd7, 2'b11, 1'b0);
        set_ch(1, 1'b1, 8'h02, 8'd7, 2'b11, 1'b0);
        step();
        vectors++; if (irq_tgt !== 1'b0 || irq_id !== 8'h01) begin miscompares++; $display("FAIL rank_tie got %b/%h want 0/01", irq_tgt, irq_id); end
        step();
        vectors++; if (irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL rank_tie_no_kill got %b want 0", irq_kill_req); end
        irq_ready = 1'b1; #1;
        vectors++; if (tgt_ready !== 2'b01) begin miscompares++; $display("FAIL rank_tie_ready got %b want 01", tgt_ready); end
        step();
        irq_ready = 1'b0;
        tgt_valid = 2'b00;
        step();
    endtask

    task automatic test_preempt();
        set_ch(0, 1'b1, 8'd5, 8'd3, 2'b00, 1'b0);
        step();
        vectors++; if (irq_valid !== 1'b1 || irq_tgt !== 1'b0) begin miscompares++; $display("FAIL pre_offer got %b/%b want 1/0", irq_valid, irq_tgt); end
        set_ch(1, 1'b1, 8'd6, 8'd1, 2'b11, 1'b0); #1;
        vectors++; if (irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL pre_kill_early got %b want 0", irq_kill_req); end
        step();
        vectors++; if (irq_kill_req !== 1'b1) begin miscompares++; $display("FAIL pre_kill got %b want 1", irq_kill_req); end
        vectors++; if (irq_valid !== 1'b1) begin miscompares++; $display("FAIL pre_kill_valid got %b want 1", irq_valid); end
        irq_kill_ack = 1'b1; #1;
        vectors++; if (tgt_kill_ack !== 2'b00) begin miscompares++; $display("FAIL pre_ack got %b want 00", tgt_kill_ack); end
        vectors++; if (tgt_ready !== 2'b00) begin miscompares++; $display("FAIL pre_ack_ready got %b want 00", tgt_ready); end
        step();
        irq_kill_ack = 1'b0; #1;
        vectors++; if (irq_kill_req !== 1'b0 || irq_valid !== 1'b0) begin miscompares++; $display("FAIL pre_idle got k=%b v=%b want 0/0", irq_kill_req, irq_valid); end
        step();
        vectors++; if (irq_tgt !== 1'b1 || irq_id !== 8'd6 || irq_mode !== 2'b11) begin miscompares++; $display("FAIL pre_reoffer got %b/%h/%b want 1/06/11", irq_tgt, irq_id, irq_mode); end
        vectors++; if (irq_valid !== 1'b1 || irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL pre_reoffer_hs got v=%b k=%b want 1/0", irq_valid, irq_kill_req); end
        irq_ready = 1'b1; #1;
        vectors++; if (tgt_ready !== 2'b10) begin miscompares++; $display("FAIL pre_ready got %b want 10", tgt_ready); end
        step();
        irq_ready = 1'b0;
        tgt_valid[1] = 1'b0; #1;
        vectors++; if (irq_valid !== 1'b0) begin miscompares++; $display("FAIL pre_gap got %b want 0", irq_valid); end
        step();
        vectors++; if (irq_tgt !== 1'b0 || irq_id !== 8'd5 || irq_valid !== 1'b1) begin miscompares++; $display("FAIL pre_pending got %b/%h/%b want 0/05/1", irq_tgt, irq_id, irq_valid); end
        tgt_valid[0] = 1'b0; #1;
        vectors++; if (irq_valid !== 1'b0 || tgt_ready !== 2'b00) begin miscompares++; $display("FAIL pre_drop got %b/%b want 0/00", irq_valid, tgt_ready); end
        step();
    endtask

    task automatic test_kill_req();
        set_ch(1, 1'b1, 8'd7, 8'd4, 2'b01, 1'b0);
        step();
        vectors++; if (irq_tgt !== 1'b1 || irq_valid !== 1'b1) begin miscompares++; $display("FAIL kr_offer got %b/%b want 1/1", irq_tgt, irq_valid); end
        tgt_kill_req[1] = 1'b1;
        step();
        vectors++; if (irq_kill_req !== 1'b1) begin miscompares++; $display("FAIL kr_kill got %b want 1", irq_kill_req); end
        step();
        vectors++; if (irq_kill_req !== 1'b1 || tgt_kill_ack !== 2'b00) begin miscompares++; $display("FAIL kr_hold got %b/%b want 1/00", irq_kill_req, tgt_kill_ack); end
        step();
        irq_kill_ack = 1'b1; #1;
        vectors++; if (tgt_kill_ack !== 2'b10) begin miscompares++; $display("FAIL kr_ack got %b want 10", tgt_kill_ack); end
        vectors++; if (tgt_ready !== 2'b00) begin miscompares++; $display("FAIL kr_ack_ready got %b want 00", tgt_ready); end
        step();
        irq_kill_ack = 1'b0; #1;
        vectors++; if (irq_kill_req !== 1'b0 || tgt_kill_ack !== 2'b00 || irq_valid !== 1'b0) begin miscompares++; $display("FAIL kr_idle got k=%b a=%b v=%b want 0/00/0", irq_kill_req, tgt_kill_ack, irq_valid); end
        tgt_valid = 2'b00;
        tgt_kill_req = 2'b00;
        step();
    endtask

    task automatic test_kill_vs_ready();
        set_ch(0, 1'b1, 8'd8, 8'd2, 2'b11, 1'b0);
        tgt_kill_req[0] = 1'b1;
        step();
        step();
        vectors++; if (irq_kill_req !== 1'b1) begin miscompares++; $display("FAIL kvr_kill got %b want 1", irq_kill_req); end
        irq_ready = 1'b1;
        irq_kill_ack = 1'b1; #1;
        vectors++; if (tgt_ready !== 2'b01) begin miscompares++; $display("FAIL kvr_ready got %b want 01", tgt_ready); end
        vectors++; if (tgt_kill_ack !== 2'b00) begin miscompares++; $display("FAIL kvr_no_ack got %b want 00", tgt_kill_ack); end
        step();
        irq_ready = 1'b0;
        irq_kill_ack = 1'b0; #1;
        vectors++; if (irq_kill_req !== 1'b0 || irq_valid !== 1'b0) begin miscompares++; $display("FAIL kvr_idle got k=%b v=%b want 0/0", irq_kill_req, irq_valid); end
        tgt_valid = 2'b00;
        tgt_kill_req = 2'b00;
        step();
    endtask

    task automatic test_withdraw_reset();
        set_ch(1, 1'b1, 8'h33, 8'd9, 2'b00, 1'b0);
        step();
        vectors++; if (irq_valid !== 1'b1) begin miscompares++; $display("FAIL wd_offer got %b want 1", irq_valid); end
        tgt_valid[1] = 1'b0; #1;
        vectors++; if (irq_valid !== 1'b0 || tgt_ready !== 2'b00) begin miscompares++; $display("FAIL wd_drop got %b/%b want 0/00", irq_valid, tgt_ready); end
        step();
        tgt_valid[1] = 1'b1; #1;
        vectors++; if (irq_valid !== 1'b0) begin miscompares++; $display("FAIL wd_idle got %b want 0", irq_valid); end
        step();
        vectors++; if (irq_valid !== 1'b1 || irq_id !== 8'h33) begin miscompares++; $display("FAIL wd_reoffer got %b/%h want 1/33", irq_valid, irq_id); end
        rst_ni = 1'b0; #1;
        vectors++; if (irq_valid !== 1'b0 || irq_kill_req !== 1'b0) begin miscompares++; $display("FAIL wd_rst_hs got %b/%b want 0/0", irq_valid, irq_kill_req); end
        vectors++; if (irq_id !== 8'd0 || irq_max !== 8'd0 || irq_mode !== 2'b00 || irq_tgt !== 1'b0) begin miscompares++; $display("FAIL wd_rst_payload got %h/%0d/%b/%b want 00/0/00/0", irq_id, irq_max, irq_mode, irq_tgt); end
        step();
        rst_ni = 1'b1; #1;
        vectors++; if (irq_valid !== 1'b0) begin miscompares++; $display("FAIL wd_rst_idle got %b want 0", irq_valid); end
        tgt_valid = 2'b00;
        step();
    endtask

    initial begin
        rst_ni = 1'b0;
        tgt_valid = '0; tgt_id = '0; tgt_max = '0; tgt_mode = '0; tgt_vsid = '0;
        tgt_v = '0; tgt_shv = '0; tgt_kill_req = '0;
        irq_ready = 1'b0; irq_kill_ack = 1'b0;
        test_reset();
        test_basic();
        test_rank();
        test_preempt();
        test_kill_req();
        test_kill_vs_ready();
        test_withdraw_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clic_irq_arbiter.md
Name: clic_irq_arbiter

Overview:
- Shares one core-side CLIC interrupt handshake port (valid/ready plus kill) between N_TARGETS upstream interrupt-target channels, e.g. separate M/S or per-domain target instances.
- Picks the highest-ranked pending request, holds its payload stable while it is offered to the core, and forwards the ready handshake back to the winner.
- Issues a kill toward the core when the winner asks to withdraw, or when a strictly higher-ranked channel becomes pending.

Parameters:
N_TARGETS, 2, number of upstream target channels (>=2, assert at elaboration)
SrcWidth, 8, interrupt id width
PrioWidth, 8, level/priority width
ModeWidth, 2, privilege mode width (U=00, S=01, M=11)
VsidWidth, 6, virtual-supervisor id width
TgtWidth, derived = $clog2(N_TARGETS), selected-channel index width (do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
tgt_valid_i  in  N_TARGETS  per-channel request valid
tgt_ready_o  out  N_TARGETS  per-channel accept pulse
tgt_id_i  in  N_TARGETS x SrcWidth  per-channel interrupt id
tgt_max_i  in  N_TARGETS x PrioWidth  per-channel level
tgt_mode_i  in  N_TARGETS x ModeWidth  per-channel mode
tgt_vsid_i  in  N_TARGETS x VsidWidth  per-channel vsid
tgt_v_i  in  N_TARGETS  per-channel virtualized flag
tgt_shv_i  in  N_TARGETS  per-channel selective-hardware-vectoring flag
tgt_kill_req_i  in  N_TARGETS  per-channel kill request
tgt_kill_ack_o  out  N_TARGETS  per-channel kill acknowledge
irq_valid_o  out  1  request to core
irq_ready_i  in  1  core accept
irq_id_o / irq_max_o / irq_mode_o / irq_vsid_o / irq_v_o / irq_shv_o  out  SrcWidth/PrioWidth/ModeWidth/VsidWidth/1/1  registered payload of the winner
irq_tgt_o  out  TgtWidth  index of the winning channel
irq_kill_req_o  out  1  kill request to core
irq_kill_ack_i  in  1  core kill acknowledge

Behaviour:
- Rank(i) = {emode, prio}, where emode = 2'b10 if mode==S and !v, else mode. So M outranks hypervisor-S, which outranks virtualized-S, which outranks U; prio is compared within equal emode.
- Winner = the valid channel with maximal rank. Ties go to the lowest index. Selection is combinational (tree or loop).
- Registers: state_q, sel_q, payload regs, kill_src_q. Reset: state IDLE; sel_q, payload and kill_src_q all zero. All outputs are 0 in reset.
- State IDLE:
  - If any tgt_valid_i is high: latch winner index and payload, go OFFER. irq_valid_o rises 1 cycle after the winner's valid rises.
  - Otherwise stay in IDLE.
- irq_valid_o = (state_q==OFFER or KILL) & tgt_valid_i[sel_q]. It is combinational on the live valid, so a channel withdrawing a cleared level-sensitive request is never accepted by the core.
- irq_kill_req_o = (state_q==KILL).
- State OFFER, evaluated in this priority order:
  1. irq_valid_o & irq_ready_i: tgt_ready_o[sel_q]=1 in the same cycle, go IDLE.
  2. !tgt_valid_i[sel_q]: go IDLE, nothing forwarded.
  3. tgt_kill_req_i[sel_q]: kill_src_q=1, go KILL.
  4. Any other valid channel with rank strictly greater than the latched rank: kill_src_q=0, go KILL (preemption).
- State KILL, evaluated in this priority order:
  1. irq_valid_o & irq_ready_i: tgt_ready_o[sel_q]=1, go IDLE. The handshake wins over the kill; no kill ack is given.
  2. !tgt_valid_i[sel_q]: go IDLE, kill_req drops, no ack.
  3. irq_kill_ack_i: tgt_kill_ack_o[sel_q] = kill_src_q in the same cycle, go IDLE. The preempted channel stays pending and is re-arbitrated.
- tgt_ready_o and tgt_kill_ack_o are single-cycle pulses, at most one bit set, only ever to sel_q.
- Payload outputs are stable from the OFFER entry until return to IDLE. Changes on tgt_*_i payload after latching are ignored.
- The minimum turnaround from IDLE back to IDLE is 2 cycles: no back-to-back offers without one IDLE cycle.
- Reset asserted mid-OFFER/KILL: state returns to IDLE and all outputs drop to 0 immediately (async).

Test Plan:
- ch0 valid (M, prio 5, id 3), core ready 2 cycles after irq_valid_o -> irq_id_o=3, irq_mode_o=11, irq_tgt_o=0; tgt_ready_o=2'b01 for exactly 1 cycle; state IDLE the next cycle.
- ch0 (S, v=1, prio 200) and ch1 (S, v=0, prio 10) valid in the same cycle -> ch1 wins (irq_tgt_o=1, irq_v_o=0). Equal ranks on both channels -> ch0 wins.
- ch0 offered (U, prio 3); ch1 becomes valid with M, prio 1 -> irq_kill_req_o=1 next cycle; irq_kill_ack_i -> tgt_kill_ack_o=0; IDLE, then ch1 offered with ch0 still pending.
- ch1 offered and asserts tgt_kill_req_i[1]; core acks after 3 cycles -> tgt_kill_ack_o=2'b10 in the ack cycle; irq_kill_req_o low next cycle.
- In KILL, core asserts irq_ready_i and irq_kill_ack_i in the same cycle -> tgt_ready_o pulses, no tgt_kill_ack_o, IDLE.
- Offered channel drops valid while the core holds ready low -> irq_valid_o falls in the same cycle, no ready pulse; then rst_ni pulsed mid-OFFER -> all outputs 0 and state IDLE.
